guard_patrol_ctrl: RTL
======================

# guard_patrol_ctrl

Parametrised multi-guard movement controller for the game logic, the successor to the single-guard patrol FSM. One shared step timer drives N independent guard FSMs. Each FSM walks a fixed square patrol (up, right, down, left) with configurable hold steps between moves. Each guard can switch into a timed chase mode on an alert, after which it resumes its patrol. Outputs feed the guard sprite position updaters in the same 3-bit direction encoding used by the player and guard motion logic.

## Interface
- N_GUARDS, 4, number of independent guard channels (1..16)
- TICK_CYCLES, 100000051, Clk cycles per movement step (>=2)
- HOLD_TICKS, 1, idle steps inserted after each move (0..15; 0 = no hold)
- CHASE_TIMEOUT, 8, alert-free steps before a chasing guard returns to patrol (1..255)
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; clock Clk
- enable  in  1  1 = timer runs and guards move; 0 = freeze
- alert  in  N_GUARDS  per-guard level, 1 = player detected
- chase_dir  in  2*N_GUARDS  per-guard direction toward the player, guard i at [2i+1:2i], same low-2-bit encoding as direction
- tick  out  1  one-cycle step strobe
- direction_guard  out  3*N_GUARDS  guard i at [3i+2:3i]; 000 left, 001 right, 010 down, 011 up, 100 none
- mode  out  N_GUARDS  1 = guard i in CHASE

## Operation
- Step timer: cnt, width $clog2(TICK_CYCLES).
  - enable=1: counts 0..TICK_CYCLES-1 and wraps to 0.
  - enable=0: holds its value and does not reset.
- tick = enable && (cnt == TICK_CYCLES-1), combinational.
- Every FSM, hold counter and chase counter changes only on an edge where tick=1.
- Patrol index pidx per guard, 2 bits: 0 up, 1 right, 2 down, 3 left. Advance is pidx+1 mod 4.
- Reset value of pidx for guard i is (1+i) mod 4, so guard 0 starts moving right.
- Per-guard states are MOVE, HOLD and CHASE. Reset state is MOVE.
  - MOVE: output is the patrol direction of pidx. On tick: if HOLD_TICKS=0, advance pidx and stay in MOVE; otherwise go to HOLD with hcnt=0.
  - HOLD: output is 100. On tick: if hcnt==HOLD_TICKS-1, advance pidx and go to MOVE; otherwise hcnt+1.
  - CHASE: output is {1'b0, chase_dir[i]} registered on each tick, then held between ticks. On a tick with alert[i]=1, ccnt reloads to CHASE_TIMEOUT. On a tick with alert[i]=0, ccnt-1. When ccnt reaches 0, go to MOVE with pidx unchanged: patrol resumes in the direction held before the chase, and hcnt is cleared.
- Any tick with alert[i]=1 puts guard i into CHASE (or keeps it there) with ccnt=CHASE_TIMEOUT.
  - Alert has priority over the MOVE/HOLD transitions and over the pidx advance on the same tick.
  - alert between ticks has no effect.
- Guards are fully independent and share only cnt and tick.
- direction_guard: the registered per-guard direction, forced to 100 combinationally while enable=0. mode is not gated by enable.

## Timing
- Reset values:
  - cnt=0, tick=0
  - every state MOVE, hcnt=0, ccnt=0, mode=0
  - direction_guard[i] = encoding of the reset pidx (guard 0 = 001, guard 1 = 010, guard 2 = 000, guard 3 = 011), or 100 if enable=0.
- First tick occurs TICK_CYCLES cycles after Reset deasserts, with enable=1 throughout.
- Latency: direction_guard and mode take their new value in the cycle after tick=1.
- chase_dir is sampled only on tick edges, so a mid-step change appears at the next step.
- enable deasserted mid-step: remaining count is preserved, so the next tick arrives (TICK_CYCLES-1-cnt) enabled cycles later.
- enable low when cnt==TICK_CYCLES-1: no tick is issued.
- Reset mid-operation, including mid-chase or mid-hold: all state returns immediately to the reset values. No partial step is carried over.

## Test plan
- Defaults for all scenarios: N_GUARDS=2, TICK_CYCLES=4, HOLD_TICKS=1, CHASE_TIMEOUT=2, enable=1.
- Patrol sequence: after Reset, tick every 4 cycles. Guard 0 outputs 001,100,010,100,000,100,011,100,001. Guard 1 outputs 010,100,000,100,011,... mode=00 throughout.
- HOLD_TICKS=0: guard 0 outputs 001,010,000,011,001, changing one cycle after each tick.
- Freeze: drop enable for 10 cycles at cnt=1. Required: both outputs 100, tick=0, cnt stays 1. After re-enable, the next tick comes 2 cycles later and the pre-freeze direction reappears.
- Chase: guard 1 in MOVE (010); alert[1]=1 across one tick with chase_dir[3:2]=00.
  - Required: mode=10 and output 000 for 3 steps, the tick with alert reloading ccnt=2 plus two decrements.
  - Then mode=00 and guard 1 resumes 010 (pidx unchanged). Guard 0 is unaffected.
- Priority: alert[0] rises on the tick that would end guard 0's HOLD. Required: CHASE entered and pidx not advanced; on exit, guard 0 resumes the pre-hold direction's successor only after a full MOVE/HOLD cycle.
- Reset mid-chase: assert Reset asynchronously between ticks with mode=01. Required: immediately mode=00, guard 0=001, guard 1=010, cnt=0, tick=0.

Source files
------------

// File: rtl/guard_patrol_ctrl.sv
// guard_patrol_ctrl
//
// Multi-guard movement controller. One shared step timer produces a one-cycle
// tick every TICK_CYCLES enabled cycles. Each guard runs its own small FSM:
// it walks a square patrol (up, right, down, left), optionally idles for
// HOLD_TICKS steps after each move, and switches into a timed CHASE mode
// whenever its alert input is high on a tick.
//
// Ports
//   Clk             in   system clock
//   Reset           in   asynchronous, active-high reset
//   enable          in   1 = timer runs and guards move, 0 = freeze
//   alert           in   [N_GUARDS]   per-guard "player detected" level
//   chase_dir       in   [2*N_GUARDS] per-guard direction toward the player
//   tick            out  one-cycle step strobe
//   direction_guard out  [3*N_GUARDS] per-guard direction
//                        000 left, 001 right, 010 down, 011 up, 100 none
//   mode            out  [N_GUARDS]   1 = guard is chasing
module guard_patrol_ctrl #(
  parameter int N_GUARDS      = 4,
  parameter int TICK_CYCLES   = 100000051,
  parameter int HOLD_TICKS    = 1,
  parameter int CHASE_TIMEOUT = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic [N_GUARDS-1:0]   alert,
  input  logic [2*N_GUARDS-1:0] chase_dir,
  output logic                  tick,
  output logic [3*N_GUARDS-1:0] direction_guard,
  output logic [N_GUARDS-1:0]   mode
);

  localparam int                CNT_W      = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TICK_CYCLES - 1);
  // HOLD is never entered when HOLD_TICKS is 0, so the value used then is moot.
  localparam logic [3:0]        HOLD_LAST  = (HOLD_TICKS == 0) ? 4'd0 : 4'(HOLD_TICKS - 1);
  localparam logic [7:0]        CHASE_LOAD = 8'(CHASE_TIMEOUT);
  localparam logic [2:0]        DIR_NONE   = 3'b100;

  typedef enum logic [1:0] {
    ST_MOVE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CHASE = 2'd2
  } guard_state_t;

  // Patrol index to motion encoding: 0 up, 1 right, 2 down, 3 left.
  function automatic logic [2:0] patrol_enc(input logic [1:0] pidx);
    logic [2:0] enc;
    case (pidx)
      2'd0:    enc = 3'b011;
      2'd1:    enc = 3'b001;
      2'd2:    enc = 3'b010;
      default: enc = 3'b000;
    endcase
    return enc;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared step timer
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Per-guard FSMs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_GUARDS; gi++) begin : g_guard
      localparam logic [1:0] PIDX_RST = 2'((1 + gi) % 4);

      guard_state_t state_q, state_d;
      logic [1:0]   pidx_q,  pidx_d;
      logic [3:0]   hcnt_q,  hcnt_d;
      logic [7:0]   ccnt_q,  ccnt_d;
      logic [2:0]   dir_q,   dir_d;
      logic [1:0]   pidx_inc;
      logic [2:0]   chase_enc;

      assign pidx_inc  = pidx_q + 2'd1;
      assign chase_enc = {1'b0, chase_dir[2*gi +: 2]};

      // dir_d is the value the guard shows for the coming step, so the
      // direction register is loaded alongside the state on every tick.
      always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        hcnt_d  = hcnt_q;
        ccnt_d  = ccnt_q;
        dir_d   = dir_q;
        if (tick) begin
          if (alert[gi]) begin
            // Alert wins over any patrol transition on this tick.
            state_d = ST_CHASE;
            ccnt_d  = CHASE_LOAD;
            dir_d   = chase_enc;
          end else begin
            case (state_q)
              ST_MOVE: begin
                if (HOLD_TICKS == 0) begin
                  pidx_d = pidx_inc;
                  dir_d  = patrol_enc(pidx_inc);
                end else begin
                  state_d = ST_HOLD;
                  hcnt_d  = 4'd0;
                  dir_d   = DIR_NONE;
                end
              end
              ST_HOLD: begin
                if (hcnt_q == HOLD_LAST) begin
                  state_d = ST_MOVE;
                  pidx_d  = pidx_inc;
                  dir_d   = patrol_enc(pidx_inc);
                end else begin
                  hcnt_d = hcnt_q + 4'd1;
                end
              end
              ST_CHASE: begin
                if (ccnt_q == 8'd0) begin
                  // Timeout expired: resume the move that was current when
                  // the chase started (pidx was never advanced).
                  state_d = ST_MOVE;
                  hcnt_d  = 4'd0;
                  dir_d   = patrol_enc(pidx_q);
                end else begin
                  ccnt_d = ccnt_q - 8'd1;
                  dir_d  = chase_enc;
                end
              end
              default: begin
                state_d = ST_MOVE;
                hcnt_d  = 4'd0;
                dir_d   = patrol_enc(pidx_q);
              end
            endcase
          end
        end
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          state_q <= ST_MOVE;
          pidx_q  <= PIDX_RST;
          hcnt_q  <= 4'd0;
          ccnt_q  <= 8'd0;
          dir_q   <= patrol_enc(PIDX_RST);
        end else begin
          state_q <= state_d;
          pidx_q  <= pidx_d;
          hcnt_q  <= hcnt_d;
          ccnt_q  <= ccnt_d;
          dir_q   <= dir_d;
        end
      end

      assign mode[gi]                 = (state_q == ST_CHASE);
      assign direction_guard[3*gi +: 3] = enable ? dir_q : DIR_NONE;
    end
  endgenerate

endmodule
